warp_tile_ctrl: RTL and testbench

- Parametrised teleport-tile controller for gym maps.
- Holds a runtime-programmable table of NUM_PAIRS linked endpoint pairs (A<->B).
- Detects when the player's reference corner lands on an enabled endpoint, then runs spin-out, teleport and spin-in phases, and publishes the opposite endpoint as the player's new top-left position.
- Runs in the system clock domain and advances one step per frame_tick. The player-movement block and sprite-direction mux consume its outputs.

---
 rtl/warp_tile_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_warp_tile_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_tile_ctrl.sv
// Teleport-tile controller: programmable table of linked endpoint pairs, spin-out /
// teleport / spin-in sequencing per video frame, and destination publication.
module warp_tile_ctrl #(
    parameter int NUM_PAIRS   = 13,
    parameter int IDX_W       = 4,
    parameter int COORD_W     = 10,
    parameter int PRE_FRAMES  = 40,
    parameter int POST_FRAMES = 20,
    parameter int DIR_PERIOD  = 10,
    parameter int OFFSET_X    = 15,
    parameter int OFFSET_Y    = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               wr_en,
    input  logic               clr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_side,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    output logic               at_tile,
    output logic [1:0]         spin_dir,
    output logic               warp_pulse,
    output logic [COORD_W-1:0] dest_x,
    output logic [COORD_W-1:0] dest_y,
    output logic [IDX_W-1:0]   pair_idx,
    output logic               in_hold
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRESPIN  = 3'd1;
    localparam logic [2:0] S_TELEPORT = 3'd2;
    localparam logic [2:0] S_POSTSPIN = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;

    localparam int MAX_FRAMES = (PRE_FRAMES > POST_FRAMES) ? PRE_FRAMES : POST_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam int SUB_W      = $clog2(DIR_PERIOD + 1);

    localparam logic [CNT_W-1:0]   PRE_LAST  = CNT_W'(PRE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POST_LAST = CNT_W'(POST_FRAMES - 1);
    localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(DIR_PERIOD - 1);
    localparam logic [COORD_W-1:0] OFF_X     = COORD_W'(OFFSET_X);
    localparam logic [COORD_W-1:0] OFF_Y     = COORD_W'(OFFSET_Y);

    logic [NUM_PAIRS-1:0] valid_q, valid_d;
    logic [COORD_W-1:0]   ep_ax_q [NUM_PAIRS];
    logic [COORD_W-1:0]   ep_ay_q [NUM_PAIRS];
    logic [COORD_W-1:0]   ep_bx_q [NUM_PAIRS];
    logic [COORD_W-1:0]   ep_by_q [NUM_PAIRS];
    logic [COORD_W-1:0]   ep_ax_d [NUM_PAIRS];
    logic [COORD_W-1:0]   ep_ay_d [NUM_PAIRS];
    logic [COORD_W-1:0]   ep_bx_d [NUM_PAIRS];
    logic [COORD_W-1:0]   ep_by_d [NUM_PAIRS];

    logic               hit_s;
    logic [IDX_W-1:0]   hit_idx_s;
    logic [COORD_W-1:0] opp_x_s, opp_y_s;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [1:0]         spin_q, spin_d;
    logic [COORD_W-1:0] lat_x_q, lat_x_d, lat_y_q, lat_y_d;
    logic [COORD_W-1:0] dest_x_q, dest_x_d, dest_y_q, dest_y_d;
    logic [IDX_W-1:0]   pair_idx_q, pair_idx_d;
    logic               warp_q, warp_d;
    logic               at_tile_q, at_tile_d;
    logic               in_hold_q, in_hold_d;

    // Table update: clear beats write; out-of-range indices select no entry.
    always_comb begin
        valid_d = valid_q;
        ep_ax_d = ep_ax_q;
        ep_ay_d = ep_ay_q;
        ep_bx_d = ep_bx_q;
        ep_by_d = ep_by_q;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                if (clr_en) begin
                    valid_d[i] = 1'b0;
                end else if (wr_en) begin
                    valid_d[i] = 1'b1;
                    if (wr_side) begin
                        ep_bx_d[i] = wr_x;
                        ep_by_d[i] = wr_y;
                    end else begin
                        ep_ax_d[i] = wr_x;
                        ep_ay_d[i] = wr_y;
                    end
                end else begin
                    valid_d[i] = valid_q[i];
                end
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
    end

    // Match search runs high-to-low so the lowest index (and side A) wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        opp_x_s   = '0;
        opp_y_s   = '0;
        for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
            if (valid_q[i] && pos_x == ep_ax_q[i] && pos_y == ep_ay_q[i]) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
                opp_x_s   = ep_bx_q[i];
                opp_y_s   = ep_by_q[i];
            end else if (valid_q[i] && pos_x == ep_bx_q[i] && pos_y == ep_by_q[i]) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
                opp_x_s   = ep_ax_q[i];
                opp_y_s   = ep_ay_q[i];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Sequencer next-state; spin direction is tracked as a sub-counter plus quadrant.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sub_d      = sub_q;
        spin_d     = spin_q;
        lat_x_d    = lat_x_q;
        lat_y_d    = lat_y_q;
        dest_x_d   = dest_x_q;
        dest_y_d   = dest_y_q;
        pair_idx_d = pair_idx_q;
        warp_d     = 1'b0;
        if (frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (hit_s) begin
                        state_d    = S_PRESPIN;
                        cnt_d      = '0;
                        sub_d      = '0;
                        spin_d     = 2'd0;
                        lat_x_d    = opp_x_s;
                        lat_y_d    = opp_y_s;
                        pair_idx_d = hit_idx_s;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRESPIN, S_POSTSPIN: begin
                    if ((state_q == S_PRESPIN && cnt_q == PRE_LAST) ||
                        (state_q == S_POSTSPIN && cnt_q == POST_LAST)) begin
                        state_d = (state_q == S_PRESPIN) ? S_TELEPORT : S_HOLD;
                        cnt_d   = '0;
                        sub_d   = '0;
                        spin_d  = 2'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (sub_q == SUB_LAST) begin
                            sub_d  = '0;
                            spin_d = spin_q + 2'd1;
                        end else begin
                            sub_d = sub_q + SUB_W'(1);
                        end
                    end
                end
                S_TELEPORT: begin
                    state_d  = S_POSTSPIN;
                    cnt_d    = '0;
                    sub_d    = '0;
                    spin_d   = 2'd0;
                    dest_x_d = lat_x_q - OFF_X;
                    dest_y_d = lat_y_q - OFF_Y;
                    warp_d   = 1'b1;
                end
                S_HOLD: begin
                    if (!hit_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sub_d   = '0;
                    spin_d  = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        at_tile_d = (state_d == S_PRESPIN) || (state_d == S_TELEPORT) || (state_d == S_POSTSPIN);
        in_hold_d = (state_d == S_HOLD);
    end

    // Valid bits and sequencer state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q    <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sub_q      <= '0;
            spin_q     <= 2'd0;
            lat_x_q    <= '0;
            lat_y_q    <= '0;
            dest_x_q   <= '0;
            dest_y_q   <= '0;
            pair_idx_q <= '0;
            warp_q     <= 1'b0;
            at_tile_q  <= 1'b0;
            in_hold_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            spin_q     <= spin_d;
            lat_x_q    <= lat_x_d;
            lat_y_q    <= lat_y_d;
            dest_x_q   <= dest_x_d;
            dest_y_q   <= dest_y_d;
            pair_idx_q <= pair_idx_d;
            warp_q     <= warp_d;
            at_tile_q  <= at_tile_d;
            in_hold_q  <= in_hold_d;
        end
    end

    // Endpoint storage is gated by the valid bits, so it needs no reset.
    always_ff @(posedge Clk) begin
        ep_ax_q <= ep_ax_d;
        ep_ay_q <= ep_ay_d;
        ep_bx_q <= ep_bx_d;
        ep_by_q <= ep_by_d;
    end

    assign at_tile    = at_tile_q;
    assign spin_dir   = spin_q;
    assign warp_pulse = warp_q;
    assign dest_x     = dest_x_q;
    assign dest_y     = dest_y_q;
    assign pair_idx   = pair_idx_q;
    assign in_hold    = in_hold_q;

endmodule

// File: tb/tb_warp_tile_ctrl.sv
// Self-checking bench for warp_tile_ctrl: directed scenarios plus randomized runs
// compared against a tick-count reference model.
module tb_warp_tile_ctrl;

    localparam int NP   = 13;
    localparam int IW   = 4;
    localparam int CW   = 10;
    localparam int PRE  = 40;
    localparam int POST = 20;
    localparam int DP   = 10;
    localparam int OX   = 15;
    localparam int OY   = 20;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic [CW-1:0] pos_x = '0, pos_y = '0;
    logic          wr_en = 1'b0, clr_en = 1'b0, wr_side = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [CW-1:0] wr_x = '0, wr_y = '0;
    logic          at_tile, warp_pulse, in_hold;
    logic [1:0]    spin_dir;
    logic [CW-1:0] dest_x, dest_y;
    logic [IW-1:0] pair_idx;

    int n_total = 0, n_pass = 0, n_fail = 0;

    // reference model: endpoint table and ticks elapsed since the trigger (-1 = not warping)
    bit m_valid [NP];
    int m_ax [NP], m_ay [NP], m_bx [NP], m_by [NP];
    int m_n = -1, m_ox = 0, m_oy = 0, m_dx = 0, m_dy = 0, m_pidx = 0;
    bit m_hold = 1'b0, m_warp = 1'b0;

    warp_tile_ctrl #(
        .NUM_PAIRS(NP), .IDX_W(IW), .COORD_W(CW), .PRE_FRAMES(PRE), .POST_FRAMES(POST),
        .DIR_PERIOD(DP), .OFFSET_X(OX), .OFFSET_Y(OY)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
        .wr_en(wr_en), .clr_en(clr_en), .wr_idx(wr_idx), .wr_side(wr_side),
        .wr_x(wr_x), .wr_y(wr_y), .at_tile(at_tile), .spin_dir(spin_dir),
        .warp_pulse(warp_pulse), .dest_x(dest_x), .dest_y(dest_y),
        .pair_idx(pair_idx), .in_hold(in_hold)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_dir();
        if (m_n < 0) return 0;
        if (m_n < PRE) return (m_n / DP) % 4;
        if (m_n == PRE) return 0;
        return ((m_n - PRE - 1) / DP) % 4;
    endfunction

    task automatic check_all(input string where);
        chk({where, ".at_tile"}, 32'(at_tile), 32'(m_n >= 0));
        chk({where, ".spin_dir"}, 32'(spin_dir), 32'(exp_dir()));
        chk({where, ".in_hold"}, 32'(in_hold), 32'(m_hold));
        chk({where, ".warp"}, 32'(warp_pulse), 32'(m_warp));
        chk({where, ".dest_x"}, 32'(dest_x), 32'(m_dx));
        chk({where, ".dest_y"}, 32'(dest_y), 32'(m_dy));
        chk({where, ".pair_idx"}, 32'(pair_idx), 32'(m_pidx));
    endtask

    task automatic find_match(output bit hit, output int idx, output int ox, output int oy);
        hit = 1'b0; idx = 0; ox = 0; oy = 0;
        for (int i = 0; i < NP; i++) begin
            if (!hit && m_valid[i]) begin
                if (int'(pos_x) == m_ax[i] && int'(pos_y) == m_ay[i]) begin
                    hit = 1'b1; idx = i; ox = m_bx[i]; oy = m_by[i];
                end else if (int'(pos_x) == m_bx[i] && int'(pos_y) == m_by[i]) begin
                    hit = 1'b1; idx = i; ox = m_ax[i]; oy = m_ay[i];
                end
            end
        end
    endtask

    task automatic model_tick();
        bit hit; int idx, ox, oy;
        find_match(hit, idx, ox, oy);
        m_warp = 1'b0;
        if (m_n >= 0) begin
            m_n++;
            if (m_n == PRE + 1) begin
                m_dx = (m_ox - OX + 1024) % 1024;
                m_dy = (m_oy - OY + 1024) % 1024;
                m_warp = 1'b1;
            end
            if (m_n == PRE + 1 + POST) begin
                m_n = -1;
                m_hold = 1'b1;
            end
        end else if (m_hold) begin
            if (!hit) m_hold = 1'b0;
        end else if (hit) begin
            m_n = 0; m_pidx = idx; m_ox = ox; m_oy = oy;
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic tick(input int gap);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        model_tick();
        check_all("tick");
        m_warp = 1'b0;
        if (gap > 0) begin
            @(negedge Clk);
            chk("warp_selfclear", 32'(warp_pulse), 32'd0);
            repeat (gap - 1) @(negedge Clk);
        end
    endtask

    task automatic tbl(input bit we, input bit ce, input int idx, input bit side, input int x, input int y);
        wr_en = we; clr_en = ce; wr_idx = IW'(idx); wr_side = side; wr_x = CW'(x); wr_y = CW'(y);
        @(negedge Clk);
        wr_en = 1'b0; clr_en = 1'b0;
        if (idx < NP) begin
            if (ce) m_valid[idx] = 1'b0;
            else if (we) begin
                m_valid[idx] = 1'b1;
                if (side) begin m_bx[idx] = x; m_by[idx] = y; end
                else begin m_ax[idx] = x; m_ay[idx] = y; end
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < NP; i++) m_valid[i] = 1'b0;
        m_n = -1; m_hold = 1'b0; m_warp = 1'b0; m_dx = 0; m_dy = 0; m_pidx = 0;
        check_all("reset");
    endtask

    task automatic set_pos(input int x, input int y);
        pos_x = CW'(x); pos_y = CW'(y);
    endtask

    initial begin
        @(negedge Clk);
        do_reset();

        // basic warp A->B, hold on arrival tile, leave
        tbl(1, 0, 0, 0, 303, 335);
        tbl(1, 0, 0, 1, 463, 383);
        set_pos(303, 335);
        repeat (PRE + 2) tick(3);
        chk("dest_x_448", 32'(dest_x), 32'd448);
        chk("dest_y_363", 32'(dest_y), 32'd363);
        set_pos(463, 383);
        repeat (POST) tick(3);
        chk("hold_reached", 32'(in_hold), 32'd1);
        repeat (3) tick(3);
        set_pos(400, 383);
        repeat (4) tick(3);
        chk("back_idle", 32'(in_hold), 32'd0);

        // priority: pairs 2 and 5 share (15,79)
        tbl(1, 0, 2, 0, 15, 79);
        tbl(1, 0, 2, 1, 700, 500);
        tbl(1, 0, 5, 0, 100, 200);
        tbl(1, 0, 5, 1, 15, 79);
        set_pos(15, 79);
        repeat (PRE + 2) tick(1);
        chk("prio_pair_idx", 32'(pair_idx), 32'd2);
        chk("prio_dest_x", 32'(dest_x), 32'd685);
        set_pos(1, 1);
        repeat (POST + 1) tick(0);

        // wrap, freeze and mid-flight rewrite of the latched pair
        tbl(1, 0, 4, 0, 600, 600);
        tbl(1, 0, 4, 1, 5, 10);
        set_pos(600, 600);
        repeat (15) tick(1);
        repeat (100) @(negedge Clk);
        check_all("freeze");
        tbl(1, 0, 4, 1, 0, 0);
        repeat (PRE + 2 - 15) tick(1);
        chk("wrap_dest_x", 32'(dest_x), 32'd1014);
        chk("wrap_dest_y", 32'(dest_y), 32'd1014);
        set_pos(1, 1);
        repeat (POST + 1) tick(0);

        // cleared pair must not trigger
        tbl(0, 1, 0, 0, 0, 0);
        set_pos(303, 335);
        repeat (3) tick(1);
        chk("cleared_no_trigger", 32'(at_tile), 32'd0);

        // reset during POSTSPIN
        set_pos(15, 79);
        repeat (PRE + 7) tick(1);
        chk("in_postspin", 32'(at_tile), 32'd1);
        do_reset();
        repeat (2) tick(1);

        // wr+clr together, and out-of-range write
        tbl(1, 0, 3, 0, 222, 333);
        tbl(1, 1, 3, 0, 222, 333);
        set_pos(222, 333);
        tick(1);
        chk("wrclr_invalid", 32'(at_tile), 32'd0);
        tbl(1, 0, 14, 0, 50, 50);
        set_pos(50, 50);
        tick(1);

        // randomized runs
        for (int it = 0; it < 4; it++) begin
            int p, s, steps;
            do_reset();
            for (int k = 0; k < 8; k++)
                tbl(1, ($urandom_range(0, 7) == 0), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15) * 64 + $urandom_range(0, 3), $urandom_range(0, 15) * 64);
            p = $urandom_range(0, NP - 1);
            tbl(1, 0, p, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
            tbl(1, 0, p, 1, $urandom_range(0, 1023), $urandom_range(0, 1023));
            s = $urandom_range(0, 1);
            if (s == 0) set_pos(m_ax[p], m_ay[p]); else set_pos(m_bx[p], m_by[p]);
            steps = 0;
            while (steps < 200 && !(steps > 0 && m_n < 0 && !m_hold)) begin
                if (m_n >= 0 && $urandom_range(0, 7) == 0)
                    set_pos($urandom_range(0, 1023), $urandom_range(0, 1023));
                if (m_n >= 0 && $urandom_range(0, 15) == 0)
                    tbl(1, 0, m_pidx, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023));
                if (m_hold) set_pos(1023, 1023);
                tick($urandom_range(0, 4));
                steps++;
            end
            chk("rand_completed", 32'(steps < 200), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
